// File: rtl/grid_streamer_if.sv
// ============================================================================
// Module      : grid_streamer_if
// Description : Memory read port, pixel stream and status bundle of grid_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grid_streamer_if;
    logic       start;
    logic       mem_rd_en;
    logic [9:0] mem_addr;
    logic       mem_rdata;
    logic [7:0] pix_data;
    logic [9:0] pix_index;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_last;
    logic       busy;
    logic       done;
    logic [9:0] ink_count;

    modport master (
        input  start, mem_rdata, pix_ready,
        output mem_rd_en, mem_addr, pix_data, pix_index, pix_valid,
               pix_last, busy, done, ink_count
    );

    modport slave (
        output start, mem_rdata, pix_ready,
        input  mem_rd_en, mem_addr, pix_data, pix_index, pix_valid,
               pix_last, busy, done, ink_count
    );
endinterface

`default_nettype wire

// File: rtl/grid_streamer.sv
// ============================================================================
// Module      : grid_streamer
// Description : Streams a GRID_SIZE x GRID_SIZE bit grid as 8-bit pixels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_streamer #(
    parameter int         GRID_SIZE  = 28,
    parameter int         NUM_PIXELS = GRID_SIZE * GRID_SIZE,
    parameter logic [7:0] PIXEL_ON   = 8'd255
) (
    input  wire logic       CLOCK_50,
    input  wire logic       resetn,
    grid_streamer_if.master bus
);

    localparam logic [9:0] c_LAST   = 10'(NUM_PIXELS - 1);
    localparam logic [9:0] c_GRID   = 10'(GRID_SIZE);
    localparam logic [9:0] c_X_LAST = 10'(GRID_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     r_state;
    logic [9:0] r_index;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_mem_rd_en;
    logic [9:0] r_mem_addr;
    logic [7:0] r_pix_data;
    logic [9:0] r_pix_index;
    logic       r_pix_valid;
    logic       r_pix_last;
    logic       r_busy;
    logic       r_done;
    logic [9:0] r_ink;

    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic [9:0] w_addr_nxt;

    // Column/row of the next cell; the address is rebuilt row-major from them.
    always_comb begin
        w_x_nxt = r_x + 10'd1;
        w_y_nxt = r_y;
        if (r_x == c_X_LAST) begin
            w_x_nxt = 10'd0;
            w_y_nxt = r_y + 10'd1;
        end
        w_addr_nxt = (w_y_nxt * c_GRID) + w_x_nxt;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_index     <= 10'd0;
            r_x         <= 10'd0;
            r_y         <= 10'd0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= 10'd0;
            r_pix_data  <= 8'd0;
            r_pix_index <= 10'd0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ink       <= 10'd0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_FETCH;
                        r_index     <= 10'd0;
                        r_x         <= 10'd0;
                        r_y         <= 10'd0;
                        r_ink       <= 10'd0;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= 10'd0;
                        r_busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_pix_data  <= bus.mem_rdata ? PIXEL_ON : 8'd0;
                    r_pix_index <= r_index;
                    r_pix_last  <= (r_index == c_LAST);
                    r_pix_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (bus.pix_ready) begin
                        r_pix_valid <= 1'b0;
                        r_pix_last  <= 1'b0;
                        if (r_pix_data != 8'd0) begin
                            r_ink <= r_ink + 10'd1;
                        end
                        if (r_index == c_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_index     <= r_index + 10'd1;
                            r_x         <= w_x_nxt;
                            r_y         <= w_y_nxt;
                            r_mem_addr  <= w_addr_nxt;
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = r_mem_rd_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.pix_data  = r_pix_data;
    assign bus.pix_index = r_pix_index;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_last  = r_pix_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ink_count = r_ink;

endmodule

`default_nettype wire
